// File: rtl/serial_cmd_pkg.sv
// Shared types and constants for the serial command latch.
package serial_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    COMMIT
  } state_t;

  localparam int SETTLE_CYCLES = 2;
  localparam int ERR_CNT_W     = 8;

endpackage

// File: rtl/serial_cmd_latch_rise_detect.sv
// Registers a level-sampled input and flags the cycle in which it goes high.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic x,
  output logic rise
);

  logic x_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_d <= 1'b0;
    end else begin
      x_d <= x;
    end
  end

  assign rise = x & ~x_d;

endmodule

// File: rtl/serial_cmd_latch.sv
// Qualifies serially assembled command words on a load strobe and writes
// valid address/data frames into a small control register bank.
module serial_cmd_latch
  import serial_cmd_pkg::*;
#(
  parameter int width     = 32,
  parameter int addr_bits = 8,
  parameter int num_regs  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sclk,
  input  logic                        load,
  input  logic [width-1:0]            shift_word,
  input  logic [$clog2(num_regs)-1:0] rd_addr,
  output logic [width-addr_bits-1:0]  rd_data,
  output logic                        wr_valid,
  output logic [addr_bits-1:0]        wr_addr,
  output logic [width-addr_bits-1:0]  wr_data,
  output logic                        frame_err,
  output logic                        addr_err,
  output logic [ERR_CNT_W-1:0]        err_count
);

  localparam int DW = width - addr_bits;
  localparam int CW = $clog2(width) + 2;
  localparam int RW = $clog2(num_regs);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [31:0] NUM_REGS_U = num_regs;
  localparam logic [CW-1:0] FRAME_LEN = CW'(width);

  logic sclk_rise;
  logic load_rise;

  rise_detect u_sclk_rise (
    .clk   (clk),
    .reset (reset),
    .x     (sclk),
    .rise  (sclk_rise)
  );

  rise_detect u_load_rise (
    .clk   (clk),
    .reset (reset),
    .x     (load),
    .rise  (load_rise)
  );

  state_t        state_reg, state_next;
  logic [SW-1:0] settle_reg, settle_next;
  logic [CW-1:0] bit_cnt_reg;
  logic [CW-1:0] frame_bits_reg;
  logic          frame_start;
  logic          commit;

  logic [addr_bits-1:0] addr_field;
  logic [DW-1:0]        data_field;
  logic                 count_ok;
  logic                 addr_ok;
  logic                 do_write;
  logic                 do_frame_err;
  logic                 do_addr_err;

  logic [DW-1:0] bank [num_regs];

  always_comb begin
    state_next  = state_reg;
    settle_next = settle_reg;
    frame_start = 1'b0;
    commit      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (load_rise) begin
          frame_start = 1'b1;
          settle_next = SW'(SETTLE_CYCLES);
          state_next  = SETTLE;
        end
      end
      SETTLE: begin
        settle_next = settle_reg - 1'b1;
        if (settle_reg == SW'(1)) begin
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        commit     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      settle_reg <= '0;
    end else begin
      state_reg  <= state_next;
      settle_reg <= settle_next;
    end
  end

  assign addr_field   = shift_word[width-1 -: addr_bits];
  assign data_field   = shift_word[DW-1:0];
  assign count_ok     = (frame_bits_reg == FRAME_LEN);
  assign addr_ok      = (32'(addr_field) < NUM_REGS_U);
  assign do_write     = commit & count_ok & addr_ok;
  assign do_frame_err = commit & ~count_ok;
  assign do_addr_err  = commit & count_ok & ~addr_ok;

  // An sclk rise coinciding with the load rise is the first bit of the next frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_reg    <= '0;
      frame_bits_reg <= '0;
    end else if (frame_start) begin
      frame_bits_reg <= bit_cnt_reg;
      bit_cnt_reg    <= sclk_rise ? CW'(1) : '0;
    end else if (sclk_rise && (bit_cnt_reg != '1)) begin
      bit_cnt_reg <= bit_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_valid  <= 1'b0;
      frame_err <= 1'b0;
      addr_err  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      err_count <= '0;
    end else begin
      wr_valid  <= do_write;
      frame_err <= do_frame_err;
      addr_err  <= do_addr_err;
      if (do_write) begin
        wr_addr <= addr_field;
        wr_data <= data_field;
      end
      if ((do_frame_err || do_addr_err) && (err_count != '1)) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

  // Read samples the pre-write contents, so a same-cycle write shows up one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < num_regs; i++) begin
        bank[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (do_write) begin
        bank[addr_field[RW-1:0]] <= data_field;
      end
      rd_data <= bank[rd_addr];
    end
  end

endmodule
